// File: rtl/mem_map_pkg.sv
// Shared address map, RISC-V load/store funct3 codes, FSM encoding and lane helpers
// for the memory/MMIO responder.
package mem_map_pkg;

  localparam logic [31:0] LED_ADDR   = 32'h8000_0000;
  localparam logic [31:0] SEG_ADDR   = 32'h8000_0004;
  localparam logic [31:0] BTN_ADDR   = 32'h8000_0008;
  localparam logic [31:0] TIMER_ADDR = 32'h8000_000C;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_RAM,
    RGN_LED,
    RGN_SEG,
    RGN_BTN,
    RGN_TIMER
  } region_t;

  // Shift the addressed lane down to bit 0, then sign- or zero-extend by funct3.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      F3_B:    return {{24{sh[7]}}, sh[7:0]};
      F3_H:    return {{16{sh[15]}}, sh[15:0]};
      F3_BU:   return {24'h0, sh[7:0]};
      F3_HU:   return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] off, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data across every lane it could land in.
  function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for the asynchronous push-button plus a one-cycle
// pulse on each synchronised rising edge.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic level,
  output logic rise
);

  logic meta;
  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      meta  <= button;
      level <= meta;
      prev  <= level;
    end
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/mem_responder.sv
// Single-request memory responder: word RAM plus LED/SEG/BTN/TIMER registers,
// three-state handshake (accept, access, respond with a one-cycle ack).
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  input  logic        button,
  output logic [3:0]  led,
  output logic [15:0] seg_data
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  state_t      state, state_next;
  logic        accept;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;

  logic [31:0] ram [MEM_WORDS];
  logic [31:0] ram_q;
  logic [31:0] timer;
  logic        sticky;
  logic        btn_level;
  logic        btn_rise;
  logic [31:0] rdata_q;
  logic        err_q;

  region_t     region;
  logic        f3_ok;
  logic        align_ok;
  logic        acc_err;
  logic        do_store;
  logic [31:0] load_word;
  logic [31:0] rdata_next;
  logic [3:0]  be;
  logic [31:0] laned;
  logic [31:0] mmio_val;

  btn_sync u_btn_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .button (button),
    .level  (btn_level),
    .rise   (btn_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ack        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          accept     = 1'b1;
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP: begin
        ack        = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      we_q     <= we;
      addr_q   <= addr;
      funct3_q <= funct3;
      wdata_q  <= wdata;
    end
  end

  // Decode and validate the latched request during ACCESS.
  always_comb begin
    region = RGN_NONE;
    if (addr_q[31:IDX_W+2] == '0) begin
      region = RGN_RAM;
    end else begin
      case ({addr_q[31:2], 2'b00})
        LED_ADDR:   region = RGN_LED;
        SEG_ADDR:   region = RGN_SEG;
        BTN_ADDR:   region = RGN_BTN;
        TIMER_ADDR: region = RGN_TIMER;
        default:    region = RGN_NONE;
      endcase
    end

    f3_ok = we_q ? (funct3_q inside {F3_B, F3_H, F3_W})
                 : (funct3_q inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

    case (funct3_q[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~addr_q[0];
      2'b10:   align_ok = (addr_q[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase

    // Narrow MMIO stores are only accepted at the register's base byte.
    acc_err = (region == RGN_NONE) || !f3_ok || !align_ok
           || (we_q && region != RGN_RAM && addr_q[1:0] != 2'b00)
           || (we_q && region == RGN_TIMER);

    case (region)
      RGN_RAM:   load_word = ram_q;
      RGN_LED:   load_word = {28'h0, led};
      RGN_SEG:   load_word = {16'h0, seg_data};
      RGN_BTN:   load_word = {30'h0, sticky, btn_level};
      RGN_TIMER: load_word = timer;
      default:   load_word = '0;
    endcase

    rdata_next = (we_q || acc_err) ? '0 : load_extend(load_word, addr_q[1:0], funct3_q);
    be         = byte_enable(addr_q[1:0], funct3_q);
    laned      = store_lanes(wdata_q, funct3_q);
    mmio_val   = laned & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    do_store   = (state == ST_ACCESS) && we_q && !acc_err;
  end

  // NOTE: RAM storage has no reset; only its write enable depends on the
  // (reset) FSM state, so an aborted access never commits.
  always_ff @(posedge clk) begin
    if (accept) ram_q <= ram[addr[IDX_W+1:2]];
    if (do_store && region == RGN_RAM) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram[addr_q[IDX_W+1:2]][8*b +: 8] <= laned[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led      <= '0;
      seg_data <= '0;
      sticky   <= 1'b0;
      timer    <= '0;
    end else begin
      timer <= timer + 32'd1;
      if (do_store && region == RGN_LED) led <= mmio_val[3:0];
      if (do_store && region == RGN_SEG) seg_data <= mmio_val[15:0];
      // A fresh press beats a write-1-to-clear landing on the same edge.
      if (btn_rise)                                           sticky <= 1'b1;
      else if (do_store && region == RGN_BTN && mmio_val[1]) sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == ST_ACCESS) begin
      rdata_q <= rdata_next;
      err_q   <= acc_err;
    end else if (state == ST_RESP) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a byte-level reference model predicts each
// response when the request is issued; a monitor checks every ack against it.
module tb_mem_responder;
  import mem_map_pkg::*;

  localparam int MEM_WORDS = 1024;
  localparam int RAM_BYTES = MEM_WORDS * 4;

  logic        clk, rst_n, req, we, button, ack, err;
  logic [31:0] addr, wdata, rdata;
  logic [2:0]  funct3;
  logic [3:0]  led;
  logic [15:0] seg_data;

  mem_responder #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .funct3(funct3),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .button(button),
    .led(led), .seg_data(seg_data)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc;

  logic [7:0]  mem_b [RAM_BYTES];
  logic [3:0]  led_m = '0;
  logic [15:0] seg_m = '0;
  logic        sticky_m = 1'b0;
  logic        btn_m = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Mirrors the free-running cycle counter: cleared by reset, +1 per edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_access(input bit w, input logic [31:0] a, input logic [2:0] f,
                              input logic [31:0] wd, input int unsigned t,
                              output logic e, output logic [31:0] rd);
    int          size;
    bit          uns, bad, is_ram, is_mmio;
    int          off;
    logic [31:0] base, regval, val;
    size = 4; uns = 0; bad = 0;
    case (f)
      3'b000:  size = 1;
      3'b001:  size = 2;
      3'b010:  size = 4;
      3'b100:  begin size = 1; uns = 1; bad = w; end
      3'b101:  begin size = 2; uns = 1; bad = w; end
      default: bad = 1;
    endcase
    if (a % size != 0) bad = 1;
    is_ram  = (a < RAM_BYTES);
    is_mmio = (a >= LED_ADDR) && (a <= LED_ADDR + 15);
    base    = a & ~32'h3;
    off     = int'(a & 32'h3);
    if (!is_ram && !is_mmio) bad = 1;
    if (w && is_mmio && (off != 0 || base == TIMER_ADDR)) bad = 1;
    e  = bad;
    rd = '0;
    if (bad) return;
    if (w) begin
      if (is_ram) begin
        for (int i = 0; i < size; i++) mem_b[a + i] = wd[8*i +: 8];
      end else begin
        val = (size == 4) ? wd : (size == 2) ? (wd & 32'hFFFF) : (wd & 32'hFF);
        if (base == LED_ADDR) led_m = val[3:0];
        if (base == SEG_ADDR) seg_m = val[15:0];
        if (base == BTN_ADDR && val[1]) sticky_m = 1'b0;
      end
    end else begin
      regval = '0;
      if (base == LED_ADDR)   regval = {28'h0, led_m};
      if (base == SEG_ADDR)   regval = {16'h0, seg_m};
      if (base == BTN_ADDR)   regval = {30'h0, sticky_m, btn_m};
      if (base == TIMER_ADDR) regval = t;
      val = '0;
      for (int i = 0; i < size; i++)
        val[8*i +: 8] = is_ram ? mem_b[a + i] : regval[8*(off + i) +: 8];
      if (!uns && size == 1 && val[7])  val[31:8]  = '1;
      if (!uns && size == 2 && val[15]) val[31:16] = '1;
      rd = val;
    end
  endtask

  // Called at a falling edge. With req still high we are in the ack cycle, so the
  // new request is accepted one edge later than from IDLE.
  task automatic issue(input bit w, input logic [31:0] a, input logic [2:0] f,
                       input logic [31:0] wd, input bit hold);
    exp_t        e;
    int unsigned acc_edge;
    bit          got;
    acc_edge = cyc + (req ? 2 : 1);
    model_access(w, a, f, wd, acc_edge, e.err, e.rdata);
    e.cyc = acc_edge + 1;
    exp_q.push_back(e);
    req = 1'b1; we = w; addr = a; funct3 = f; wdata = wd;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = ack;
    end
    check("ack_seen", {31'h0, got}, 32'h1);
    if (!got) exp_q.delete();
    if (!hold) begin
      req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic release_req();
    if (req) begin
      req = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {31'h0, ack}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("ack_cycle", cyc, e.cyc);
          check("err", {31'h0, err}, {31'h0, e.err});
          check("rdata", rdata, e.rdata);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; funct3 = '0; wdata = '0; button = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_led", {28'h0, led}, 32'h0);
    check("rst_seg", {16'h0, seg_data}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Initialise a RAM window and the top word back-to-back.
    for (int i = 0; i < 16; i++) issue(1'b1, 32'(4 * i), F3_W, $urandom(), 1'b1);
    issue(1'b1, RAM_BYTES - 4, F3_W, 32'hCAFE_F00D, 1'b0);
    issue(1'b0, RAM_BYTES - 4, F3_W, 32'h0, 1'b0);
    issue(1'b0, RAM_BYTES, F3_W, 32'h0, 1'b0);

    issue(1'b1, 32'h10, F3_W, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 32'h13, F3_B, 32'h0, 1'b0);
    issue(1'b0, 32'h13, F3_BU, 32'h0, 1'b0);

    issue(1'b1, 32'h20, F3_W, 32'h1122_3344, 1'b0);
    issue(1'b1, 32'h22, F3_H, 32'h0000_AAAA, 1'b0);
    issue(1'b0, 32'h20, F3_W, 32'h0, 1'b0);
    issue(1'b0, 32'h22, F3_H, 32'h0, 1'b0);

    issue(1'b0, 32'h21, F3_W, 32'h0, 1'b0);
    issue(1'b1, 32'h23, F3_H, 32'hFFFF, 1'b0);
    issue(1'b0, 32'h4000_0000, F3_W, 32'h0, 1'b0);
    issue(1'b1, 32'h20, 3'b100, 32'h0, 1'b0);
    issue(1'b0, 32'h20, 3'b011, 32'h0, 1'b0);
    issue(1'b1, TIMER_ADDR, F3_W, 32'h0, 1'b0);
    issue(1'b0, 32'h20, F3_W, 32'h0, 1'b0);

    issue(1'b1, LED_ADDR, F3_W, 32'h5, 1'b0);
    check("led_after_sw", {28'h0, led}, 32'h5);
    issue(1'b1, SEG_ADDR, F3_W, 32'h1234, 1'b0);
    check("seg_after_sw", {16'h0, seg_data}, 32'h1234);
    issue(1'b1, LED_ADDR + 1, F3_B, 32'hA, 1'b0);
    check("led_after_bad_sb", {28'h0, led}, 32'h5);
    issue(1'b0, SEG_ADDR, F3_W, 32'h0, 1'b0);
    issue(1'b0, TIMER_ADDR, F3_W, 32'h0, 1'b1);
    issue(1'b0, TIMER_ADDR, F3_W, 32'h0, 1'b0);

    // Button: press, read, clear, then a clear landing on a fresh press.
    button = 1'b1; repeat (3) @(negedge clk);
    button = 1'b0; repeat (4) @(negedge clk);
    sticky_m = 1'b1;
    issue(1'b0, BTN_ADDR, F3_W, 32'h0, 1'b0);
    issue(1'b1, BTN_ADDR, F3_W, 32'h2, 1'b0);
    issue(1'b0, BTN_ADDR, F3_W, 32'h0, 1'b0);
    button = 1'b1;
    @(negedge clk);
    issue(1'b1, BTN_ADDR, F3_W, 32'h2, 1'b0);
    sticky_m = 1'b1;
    btn_m    = 1'b1;
    issue(1'b0, BTN_ADDR, F3_W, 32'h0, 1'b0);
    button = 1'b0; repeat (4) @(negedge clk);
    btn_m = 1'b0;

    for (int n = 0; n < 200; n++) begin
      bit          w;
      logic [2:0]  f;
      logic [31:0] a;
      int          k;
      k = $urandom_range(0, 9);
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      if (k < 6) begin
        a = 32'($urandom_range(0, 63));
      end else if (k < 9) begin
        a = LED_ADDR + 32'(4 * $urandom_range(0, 3));
        if (w && a == SEG_ADDR && f == F3_B) f = F3_W;
      end else begin
        a = 32'h0001_0000 + 32'($urandom_range(0, 255));
      end
      issue(w, a, f, $urandom(), 1'($urandom_range(0, 1)));
    end
    release_req();

    // Reset in the middle of an ACCESS cycle must abort the store.
    req = 1'b1; we = 1'b1; addr = 32'h30; funct3 = F3_W; wdata = 32'h1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_ack", {31'h0, ack}, 32'h0);
    end
    check("abort_led", {28'h0, led}, 32'h0);
    check("abort_seg", {16'h0, seg_data}, 32'h0);
    led_m = '0; seg_m = '0; sticky_m = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'h30, F3_W, 32'h0, 1'b0);
    issue(1'b0, BTN_ADDR, F3_W, 32'h0, 1'b0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning number of 32-bit RAM words (power of two).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  1  CPU access request; held high by the initiator until ack.
REQ-005 SHALL have port we  input  1  1 = store, 0 = load; stable while req high.
REQ-006 SHALL have port addr  input  32  byte address; stable while req high.
REQ-007 SHALL have port funct3  input  3  RISC-V load/store funct3 (size and signedness).
REQ-008 SHALL have port wdata  input  32  store data, right-aligned (bits [7:0] for sb).
REQ-009 SHALL have port rdata  output  32  load result, aligned and extended; valid only while ack high.
REQ-010 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  valid with ack; 1 = access rejected.
REQ-012 SHALL have port button  input  1  asynchronous push-button level.
REQ-013 SHALL have ports led  output  4  and  seg_data  output  16  register-driven outputs for LEDs and seven-segment display.

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; IDLE leaves only when req=1; ACCESS and RESP last exactly one cycle each.
REQ-015 SHALL latch we/addr/funct3/wdata on the IDLE->ACCESS edge; later input changes ignored until the next IDLE.
REQ-016 SHALL assert ack for exactly the RESP cycle (2 cycles after acceptance); req still high in the IDLE after RESP starts a new access.
REQ-017 SHALL decode: 0x0000_0000..MEM_WORDS*4-1 RAM; 0x8000_0000 LED (RW, bits[3:0]); 0x8000_0004 SEG (RW, bits[15:0]); 0x8000_0008 BTN (bit0 synced level RO, bit1 sticky press flag, write-1-to-clear); 0x8000_000C TIMER (RO, free-running 32-bit cycle counter, wraps 0xFFFF_FFFF->0).
REQ-018 SHALL support loads lb(000) lh(001) lw(010) lbu(100) lhu(101) and stores sb(000) sh(001) sw(010); lane chosen by addr[1:0]; signed loads sign-extend, unsigned zero-extend.
REQ-019 SHALL commit RAM stores on the ACCESS edge using byte enables only; untouched bytes of the word unchanged.
REQ-020 SHALL flag err=1, no state change, rdata=0 for: unmapped address, halfword with addr[0]=1, word with addr[1:0]!=0, illegal funct3, store to TIMER.
REQ-021 SHALL apply MMIO stores: LED/SEG take the low bits of the byte-laned value; sb/sh to MMIO allowed at offset 0 only, else err.
REQ-022 SHALL synchronise button through two flops; sticky flag sets on synced rising edge; set wins over a same-cycle clear.
REQ-023 SHALL return rdata for TIMER equal to the counter value sampled on the ACCESS edge.

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE, ack=0, err=0, rdata=0, led=0, seg_data=0, sticky=0, TIMER=0, sync flops=0.
REQ-025 SHALL abort an in-flight access on reset with no ack; a store not yet past its ACCESS edge SHALL NOT commit.
REQ-026 SHALL NOT reset RAM contents.

Structure
REQ-027 SHALL take address-map constants, funct3 codes and FSM state encoding from shared package mem_map_pkg.
REQ-028 SHALL instantiate one sub-module btn_sync (2-flop synchroniser plus rising-edge detect).

Verification
REQ-029 sw 0xDEADBEEF to 0x10, then lb 0x13 -> ack 2 cycles after each req, rdata 0xFFFFFFDE; lbu 0x13 -> 0x000000DE.
REQ-030 sw 0x11223344 to 0x20, sh 0xAAAA to 0x22, lw 0x20 -> 0xAAAA3344; lh 0x22 -> 0xFFFFAAAA.
REQ-031 lw 0x21, sh 0x23, lw 0x4000_0000 -> ack with err=1, RAM at 0x20 unchanged.
REQ-032 sw 0x5 to 0x8000_0000, sw 0x1234 to 0x8000_0004 -> led=0x5, seg_data=0x1234 one cycle after ACCESS.
REQ-033 button pulse, lw 0x8000_0008 -> bit1=1; sw 0x2 there -> bit1=0; clear coincident with new press -> bit1=1.
REQ-034 rst_n low during ACCESS of sw 0x1 to 0x30 -> no ack, led=0, RAM word 0x30 unchanged.
